bf16_op_sequencer: RTL and testbench

//  Request/response front-end for the bfloat16 operator datapath. Accepts one
//  {mode, in1, in2} request over a valid/ready handshake and registers it.

---
 rtl/bf16_op_sequencer.sv | 173 +++++++++++++++++
 tb/tb_bf16_op_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf16_op_sequencer.sv
// Request/response sequencer in front of the bf16 op_mux: registers one request, holds operands for a per-mode latency, returns the result.
// Optional sticky overflow flag is built when STICKY_OVF_EN is defined.
module bf16_op_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int MODE_WIDTH = 2,
  parameter int ADD_LAT    = 1,
  parameter int SUB_LAT    = 1,
  parameter int MUL_LAT    = 2,
  parameter int DIV_LAT    = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [MODE_WIDTH-1:0] req_mode_i,
  input  logic [DATA_WIDTH-1:0] req_in1_i,
  input  logic [DATA_WIDTH-1:0] req_in2_i,
  output logic [MODE_WIDTH-1:0] mux_mode_o,
  output logic [DATA_WIDTH-1:0] mux_in1_o,
  output logic [DATA_WIDTH-1:0] mux_in2_o,
  input  logic [DATA_WIDTH-1:0] mux_out_i,
  input  logic                  mux_ovf_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  rsp_ovf_o,
  output logic                  rsp_illegal_o,
  input  logic                  clr_ovf_i,
  output logic                  sticky_ovf_o
);

  localparam int MAX_AS  = (ADD_LAT > SUB_LAT) ? ADD_LAT : SUB_LAT;
  localparam int MAX_MD  = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int MAX_LAT = (MAX_AS > MAX_MD) ? MAX_AS : MAX_MD;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  localparam logic [MODE_WIDTH-1:0] MODE_ADD = MODE_WIDTH'(0);
  localparam logic [MODE_WIDTH-1:0] MODE_SUB = MODE_WIDTH'(1);
  localparam logic [MODE_WIDTH-1:0] MODE_MUL = MODE_WIDTH'(2);
  localparam logic [MODE_WIDTH-1:0] MODE_DIV = MODE_WIDTH'(3);

  localparam logic [CNT_W-1:0] ADD_CNT = CNT_W'(ADD_LAT - 1);
  localparam logic [CNT_W-1:0] SUB_CNT = CNT_W'(SUB_LAT - 1);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [MODE_WIDTH-1:0] mode_q, mode_d;
  logic [DATA_WIDTH-1:0] in1_q, in1_d;
  logic [DATA_WIDTH-1:0] in2_q, in2_d;
  logic                  ill_q, ill_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  ovf_q, ovf_d;
  logic                  rsp_ill_q, rsp_ill_d;
  logic                  capture;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    in1_d     = in1_q;
    in2_d     = in2_q;
    ill_d     = ill_q;
    data_d    = data_q;
    ovf_d     = ovf_q;
    rsp_ill_d = rsp_ill_q;
    capture   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          mode_d  = req_mode_i;
          in1_d   = req_in1_i;
          in2_d   = req_in2_i;
          ill_d   = 1'b0;
          state_d = S_EXEC;
          case (req_mode_i)
            MODE_ADD: cnt_d = ADD_CNT;
            MODE_SUB: cnt_d = SUB_CNT;
            MODE_MUL: cnt_d = MUL_CNT;
            MODE_DIV: cnt_d = DIV_CNT;
            default: begin
              cnt_d = '0;
              ill_d = 1'b1;
            end
          endcase
        end
      end
      S_EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          capture = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // An illegal mode never exposes whatever the mux happens to drive.
    if (capture) begin
      data_d    = ill_q ? '0 : mux_out_i;
      ovf_d     = ill_q ? 1'b0 : mux_ovf_i;
      rsp_ill_d = ill_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      mode_q    <= '0;
      in1_q     <= '0;
      in2_q     <= '0;
      ill_q     <= 1'b0;
      data_q    <= '0;
      ovf_q     <= 1'b0;
      rsp_ill_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      in1_q     <= in1_d;
      in2_q     <= in2_d;
      ill_q     <= ill_d;
      data_q    <= data_d;
      ovf_q     <= ovf_d;
      rsp_ill_q <= rsp_ill_d;
    end
  end

  assign req_ready_o   = (state_q == S_IDLE);
  assign rsp_valid_o   = (state_q == S_DONE);
  assign mux_mode_o    = mode_q;
  assign mux_in1_o     = in1_q;
  assign mux_in2_o     = in2_q;
  assign rsp_data_o    = data_q;
  assign rsp_ovf_o     = ovf_q;
  assign rsp_illegal_o = rsp_ill_q;

`ifdef STICKY_OVF_EN
  logic sticky_q, sticky_d;

  // Set has priority so an overflow landing on the clear edge is not lost.
  always_comb begin
    sticky_d = sticky_q;
    if (clr_ovf_i) sticky_d = 1'b0;
    if (capture && !ill_q && mux_ovf_i) sticky_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sticky_q <= 1'b0;
    else       sticky_q <= sticky_d;
  end

  assign sticky_ovf_o = sticky_q;
`else
  logic unused_clr_ovf;
  assign unused_clr_ovf = clr_ovf_i;
  assign sticky_ovf_o   = 1'b0;
`endif

endmodule

// File: tb/tb_bf16_op_sequencer.sv
// Scoreboard bench for bf16_op_sequencer: directed requests against a tabulated op_mux stand-in.
module tb_bf16_op_sequencer;
  localparam int DW = 16;
  localparam int MW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready;
  logic [MW-1:0] req_mode;
  logic [DW-1:0] req_in1, req_in2;
  logic [MW-1:0] mux_mode;
  logic [DW-1:0] mux_in1, mux_in2, mux_out;
  logic          mux_ovf;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_ovf, rsp_illegal;
  logic          clr_ovf, sticky_ovf;

  bf16_op_sequencer dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_mode_i   (req_mode),
    .req_in1_i    (req_in1),
    .req_in2_i    (req_in2),
    .mux_mode_o   (mux_mode),
    .mux_in1_o    (mux_in1),
    .mux_in2_o    (mux_in2),
    .mux_out_i    (mux_out),
    .mux_ovf_i    (mux_ovf),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_data_o   (rsp_data),
    .rsp_ovf_o    (rsp_ovf),
    .rsp_illegal_o(rsp_illegal),
    .clr_ovf_i    (clr_ovf),
    .sticky_ovf_o (sticky_ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // op_mux stand-in: hand-tabulated bf16 results for the operand sets used below.
  always_comb begin
    mux_out = 16'hDEAD;
    mux_ovf = 1'b0;
    case ({mux_mode, mux_in1, mux_in2})
      {2'd0, 16'h3F80, 16'h4000}: mux_out = 16'h4040;
      {2'd0, 16'h4000, 16'h4000}: mux_out = 16'h4080;
      {2'd1, 16'h4040, 16'h3F80}: mux_out = 16'h4000;
      {2'd2, 16'h4000, 16'h4040}: mux_out = 16'h40C0;
      {2'd2, 16'h7F00, 16'h7F00}: begin mux_out = 16'h7F80; mux_ovf = 1'b1; end
      {2'd3, 16'h4040, 16'h4000}: mux_out = 16'h3FC0;
      {2'd3, 16'h3F80, 16'h4000}: mux_out = 16'h3F00;
      default: ;
    endcase
  end

  typedef struct {
    logic [MW-1:0] mode;
    logic [DW-1:0] in1, in2, data;
    logic          ovf;
    int            lat;
    int            acc;
  } exp_t;

  exp_t exp_q[$];

  // Monitor: compares each new response, then checks it is held while stalled.
  logic          seen = 1'b0;
  logic [DW-1:0] hold_data;
  logic          hold_ovf;
  exp_t          cur;

  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid) begin
        if (!seen) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got data %0h with no request outstanding", rsp_data);
          end else begin
            cur = exp_q.pop_front();
            chk("latency", cyc - cur.acc, cur.lat);
            chk("rsp_data", {16'h0, rsp_data}, {16'h0, cur.data});
            chk("rsp_ovf", {31'h0, rsp_ovf}, {31'h0, cur.ovf});
            chk("rsp_illegal", {31'h0, rsp_illegal}, 32'h0);
            hold_data = rsp_data;
            hold_ovf  = rsp_ovf;
            seen      = 1'b1;
          end
        end else begin
          chk("hold_data", {16'h0, rsp_data}, {16'h0, hold_data});
          chk("hold_ovf", {31'h0, rsp_ovf}, {31'h0, hold_ovf});
          chk("hold_req_ready", {31'h0, req_ready}, 32'h0);
        end
      end else begin
        seen = 1'b0;
        if (!req_ready && exp_q.size() != 0) begin
          chk("exec_mux_mode", {30'h0, mux_mode}, {30'h0, exp_q[0].mode});
          chk("exec_mux_in1", {16'h0, mux_in1}, {16'h0, exp_q[0].in1});
          chk("exec_mux_in2", {16'h0, mux_in2}, {16'h0, exp_q[0].in2});
        end
      end
    end
  end

  task automatic send(input logic [MW-1:0] m, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [DW-1:0] d, input logic o, input int lat);
    exp_t e;
    int   t;
    t = 0;
    req_valid = 1'b1;
    req_mode  = m;
    req_in1   = a;
    req_in2   = b;
    while (!req_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 100) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: req_ready %0b expected 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_in1   = 16'hFFFF;
    req_in2   = 16'hFFFF;
    e.mode = m; e.in1 = a; e.in2 = b; e.data = d; e.ovf = o; e.lat = lat; e.acc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || !req_ready) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: pending %0d expected 0", exp_q.size());
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_mode  = '0;
    req_in1   = '0;
    req_in2   = '0;
    rsp_ready = 1'b1;
    clr_ovf   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", {31'h0, req_ready}, 32'h1);
    chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("reset_rsp_data", {16'h0, rsp_data}, 32'h0);
    chk("reset_mux_in1", {16'h0, mux_in1}, 32'h0);
    chk("reset_sticky", {31'h0, sticky_ovf}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // ADD 1.0 + 2.0 = 3.0
    send(2'd0, 16'h3F80, 16'h4000, 16'h4040, 1'b0, 1);
    wait_idle();
    // DIV 3.0 / 2.0 = 1.5, long latency with operands held
    send(2'd3, 16'h4040, 16'h4000, 16'h3FC0, 1'b0, 8);
    wait_idle();
    send(2'd2, 16'h4000, 16'h4040, 16'h40C0, 1'b0, 2);
    wait_idle();
    send(2'd0, 16'h4000, 16'h4000, 16'h4080, 1'b0, 1);
    wait_idle();

    // MUL overflow and sticky flag
    send(2'd2, 16'h7F00, 16'h7F00, 16'h7F80, 1'b1, 2);
    wait_idle();
    repeat (2) @(posedge clk);
    #1;
`ifdef STICKY_OVF_EN
    chk("sticky_set", {31'h0, sticky_ovf}, 32'h1);
`else
    chk("sticky_tied", {31'h0, sticky_ovf}, 32'h0);
`endif
    clr_ovf = 1'b1;
    @(posedge clk); #1;
    clr_ovf = 1'b0;
    chk("sticky_cleared", {31'h0, sticky_ovf}, 32'h0);

    // SUB with response stalled for 5 cycles
    rsp_ready = 1'b0;
    send(2'd1, 16'h4040, 16'h3F80, 16'h4000, 1'b0, 1);
    begin
      int t;
      t = 0;
      while (!rsp_valid && t < 50) begin
        @(posedge clk); #1;
        t++;
      end
      if (t >= 50) begin
        checks++;
        errors++;
        $display("FAIL rsp_timeout: rsp_valid %0b expected 1", rsp_valid);
      end
    end
    repeat (5) @(posedge clk);
    #1;
    chk("stall_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("after_stall_idle", {31'h0, req_ready}, 32'h1);
    wait_idle();

    // Reset during DIV EXEC: no response, outputs cleared
    send(2'd3, 16'h3F80, 16'h4000, 16'h3F00, 1'b0, 8);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_data", {16'h0, rsp_data}, 32'h0);
    chk("rst_rsp_ovf", {31'h0, rsp_ovf}, 32'h0);
    chk("rst_mux_in1", {16'h0, mux_in1}, 32'h0);
    chk("rst_mux_mode", {30'h0, mux_mode}, 32'h0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("no_rsp_after_rst", {31'h0, rsp_valid}, 32'h0);

    // Pipeline still functional after the reset
    send(2'd3, 16'h4040, 16'h4000, 16'h3FC0, 1'b0, 8);
    wait_idle();

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
